// File: rtl/if_id_fetch_stage_pkg.sv
// ============================================================================
// if_id_fetch_stage_pkg : shared constants, FSM state type and next-PC helper
// Rev 1.0
// ============================================================================
`default_nettype none

package if_id_fetch_stage_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_t;

   localparam logic [2:0] NPC_SEQ      = 3'b000;
   localparam logic [2:0] NPC_REDIRECT = 3'b001;
   localparam logic [2:0] NPC_HOLD     = 3'b010;

   // Redirect targets are forced word aligned
   function automatic logic [31:0] next_pc(input logic [2:0]  op,
                                           input logic [31:0] cur,
                                           input logic [31:0] target);
      case (op)
         NPC_SEQ:      next_pc = cur + 32'd4;
         NPC_REDIRECT: next_pc = {target[31:2], 2'b00};
         default:      next_pc = cur;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with hold and NOP-bubble insertion
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_reg
   import if_id_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        valid
);

   // A flush keeps the old pc; only instr/valid are replaced by a bubble
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc    <= 32'h0;
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (hold) begin
         pc    <= pc;
         instr <= instr;
         valid <= valid;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else begin
         pc    <= pc_in;
         instr <= instr_in;
         valid <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// if_id_fetch_stage : PC/fetch FSM feeding the IF/ID register; optional
// stall/flush performance counters under FETCH_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module if_id_fetch_stage
   import if_id_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        IF_ID_flush,
   input  logic        PCWrite,
   input  logic [31:0] npc_target,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_instr,
   output logic        IF_ID_valid,
   output logic        ID_EX_bubble
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   fetch_state_t state;

   logic       running;
   logic       stall_any;
   logic       take_stall;
   logic       take_flush;
   logic       take_wait;
   logic       take_fetch;
   logic [2:0] npc_op;

   assign running    = (state != ST_BOOT);
   assign stall_any  = stall | ~PCWrite;

   // Branch decode in priority order: stall > flush > imem wait > fetch
   assign take_stall = running & stall_any;
   assign take_flush = running & ~stall_any & IF_ID_flush;
   assign take_wait  = running & ~stall_any & ~IF_ID_flush & ~imem_ready;
   assign take_fetch = running & ~stall_any & ~IF_ID_flush & imem_ready;

   assign imem_req     = running & ~stall;
   assign imem_addr    = pc;
   assign ID_EX_bubble = stall;

   always_comb begin
      npc_op = NPC_HOLD;
      if (take_flush)
         npc_op = NPC_REDIRECT;
      else if (take_fetch)
         npc_op = NPC_SEQ;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_BOOT;
         pc    <= RESET_PC;
      end else begin
         pc <= next_pc(npc_op, pc, npc_target);
         case (state)
            ST_BOOT: state <= ST_RUN;
            default: begin
               if (take_flush || take_fetch)
                  state <= ST_RUN;
               else if (take_wait)
                  state <= ST_WAIT;
            end
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rstn     (rstn),
      .hold     (~running | stall_any),
      .flush    (take_flush | take_wait),
      .pc_in    (pc),
      .instr_in (imem_rdata),
      .pc       (IF_ID_pc),
      .instr    (IF_ID_instr),
      .valid    (IF_ID_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= 32'h0;
         flush_cnt <= 32'h0;
      end else begin
         if (take_stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (take_flush && (flush_cnt != 32'hFFFF_FFFF))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
// ============================================================================
// tb_if_id_fetch_stage : vector table, corner sequences and random run
// against a behavioural fetch model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_id_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic        IF_ID_flush;
   logic        PCWrite;
   logic [31:0] npc_target;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] IF_ID_pc;
   logic [31:0] IF_ID_instr;
   logic        IF_ID_valid;
   logic        ID_EX_bubble;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   always #5 clk = ~clk;

   if_id_fetch_stage dut (
      .clk          (clk),
      .rstn         (rstn),
      .stall        (stall),
      .IF_ID_flush  (IF_ID_flush),
      .PCWrite      (PCWrite),
      .npc_target   (npc_target),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .pc           (pc),
      .IF_ID_pc     (IF_ID_pc),
      .IF_ID_instr  (IF_ID_instr),
      .IF_ID_valid  (IF_ID_valid),
      .ID_EX_bubble (ID_EX_bubble)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   typedef struct {
      logic        s, f, w, r;
      logic [31:0] npc, rd;
      logic        req;
      logic [31:0] pc, ipc, ins;
      logic        v;
   } vec_t;

   vec_t tbl[$];

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   logic [31:0] m_pc, m_ipc, m_ins, m_scnt, m_fcnt;
   logic        m_v;
   int          m_cycles_since_reset;

   logic        seen_req, seen_bub, exp_req;

   function automatic vec_t mk(logic s, logic f, logic w, logic r,
                               logic [31:0] npc, logic [31:0] rd, logic req,
                               logic [31:0] p, logic [31:0] ipc,
                               logic [31:0] ins, logic v);
      vec_t t;
      t.s = s; t.f = f; t.w = w; t.r = r; t.npc = npc; t.rd = rd;
      t.req = req; t.pc = p; t.ipc = ipc; t.ins = ins; t.v = v;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_ipc = 32'h0; m_ins = NOP; m_v = 1'b0;
      m_scnt = 32'h0; m_fcnt = 32'h0;
      m_cycles_since_reset = 0;
   endtask

   // Drive inputs, observe combinational outputs, advance model and DUT one edge
   task automatic apply(input logic s, input logic f, input logic w, input logic r,
                        input logic [31:0] npc, input logic [31:0] rd);
      stall = s; IF_ID_flush = f; PCWrite = w; imem_ready = r;
      npc_target = npc; imem_rdata = rd;
      #1;
      seen_req = imem_req;
      seen_bub = ID_EX_bubble;
      exp_req  = (m_cycles_since_reset != 0) && !s;
      if (m_cycles_since_reset == 0) begin
         // first cycle after reset only boots
      end else if (s || !w) begin
         if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      end else if (f) begin
         m_pc  = npc & 32'hFFFF_FFFC;
         m_ins = NOP; m_v = 1'b0;
         if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
      end else if (!r) begin
         m_ins = NOP; m_v = 1'b0;
      end else begin
         m_ipc = m_pc; m_ins = rd; m_v = 1'b1;
         m_pc  = m_pc + 32'd4;
      end
      m_cycles_since_reset++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".imem_req"},  {31'h0, seen_req}, {31'h0, exp_req});
      chk({tag, ".bubble"},    {31'h0, seen_bub}, {31'h0, stall});
      chk({tag, ".pc"},        pc,          m_pc);
      chk({tag, ".imem_addr"}, imem_addr,   m_pc);
      chk({tag, ".IF_ID_pc"},  IF_ID_pc,    m_ipc);
      chk({tag, ".IF_ID_ins"}, IF_ID_instr, m_ins);
      chk({tag, ".IF_ID_v"},   {31'h0, IF_ID_valid}, {31'h0, m_v});
`ifdef FETCH_PERF_CNT_EN
      chk({tag, ".stall_cnt"}, stall_cnt, m_scnt);
      chk({tag, ".flush_cnt"}, flush_cnt, m_fcnt);
`endif
   endtask

   initial begin
      rstn = 1'b0; stall = 1'b0; IF_ID_flush = 1'b0; PCWrite = 1'b1;
      imem_ready = 1'b1; npc_target = 32'h0; imem_rdata = 32'h0;
      model_reset();

      //   s  f  w  r  npc           rd            req pc            ipc           instr         v
      tbl.push_back(mk(0,0,1,1, 32'h0,        32'h00500093, 0, 32'h0,   32'h0,   NOP,          0));
      tbl.push_back(mk(0,0,1,1, 32'h0,        32'h00500093, 1, 32'h4,   32'h0,   32'h00500093, 1));
      tbl.push_back(mk(0,0,1,1, 32'h0,        32'h11111111, 1, 32'h8,   32'h4,   32'h11111111, 1));
      tbl.push_back(mk(0,0,1,1, 32'h0,        32'h22222222, 1, 32'hC,   32'h8,   32'h22222222, 1));
      tbl.push_back(mk(0,0,1,1, 32'h0,        32'h33333333, 1, 32'h10,  32'hC,   32'h33333333, 1));
      tbl.push_back(mk(1,0,0,1, 32'h0,        32'hDEAD0001, 0, 32'h10,  32'hC,   32'h33333333, 1));
      tbl.push_back(mk(1,0,0,1, 32'h0,        32'hDEAD0002, 0, 32'h10,  32'hC,   32'h33333333, 1));
      tbl.push_back(mk(1,1,0,1, 32'h300,      32'hDEAD0003, 0, 32'h10,  32'hC,   32'h33333333, 1));
      tbl.push_back(mk(0,1,1,0, 32'h200,      32'hDEAD0004, 1, 32'h200, 32'hC,   NOP,          0));
      tbl.push_back(mk(0,0,1,1, 32'h0,        32'h44444444, 1, 32'h204, 32'h200, 32'h44444444, 1));
      tbl.push_back(mk(0,1,1,1, 32'h43,       32'hDEAD0005, 1, 32'h40,  32'h200, NOP,          0));
      tbl.push_back(mk(0,0,1,0, 32'h0,        32'hDEAD0006, 1, 32'h40,  32'h200, NOP,          0));
      tbl.push_back(mk(0,0,1,0, 32'h0,        32'hDEAD0007, 1, 32'h40,  32'h200, NOP,          0));
      tbl.push_back(mk(0,0,1,0, 32'h0,        32'hDEAD0008, 1, 32'h40,  32'h200, NOP,          0));
      tbl.push_back(mk(0,0,1,1, 32'h0,        32'h55555555, 1, 32'h44,  32'h40,  32'h55555555, 1));
      tbl.push_back(mk(0,0,0,1, 32'h0,        32'hDEAD0009, 1, 32'h44,  32'h40,  32'h55555555, 1));

      // Reset state
      @(posedge clk); #1;
      chk("rst.pc",       pc,          32'h0);
      chk("rst.IF_ID_pc", IF_ID_pc,    32'h0);
      chk("rst.instr",    IF_ID_instr, NOP);
      chk("rst.valid",    {31'h0, IF_ID_valid}, 32'h0);
      chk("rst.imem_req", {31'h0, imem_req},    32'h0);
      @(posedge clk); #1;
      rstn = 1'b1;

      foreach (tbl[i]) begin
         apply(tbl[i].s, tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].npc, tbl[i].rd);
         chk($sformatf("vec%0d.imem_req", i), {31'h0, seen_req}, {31'h0, tbl[i].req});
         chk($sformatf("vec%0d.bubble", i),   {31'h0, seen_bub}, {31'h0, tbl[i].s});
         chk($sformatf("vec%0d.pc", i),       pc,          tbl[i].pc);
         chk($sformatf("vec%0d.IF_ID_pc", i), IF_ID_pc,    tbl[i].ipc);
         chk($sformatf("vec%0d.instr", i),    IF_ID_instr, tbl[i].ins);
         chk($sformatf("vec%0d.valid", i),    {31'h0, IF_ID_valid}, {31'h0, tbl[i].v});
`ifdef FETCH_PERF_CNT_EN
         chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, m_scnt);
         chk($sformatf("vec%0d.flush_cnt", i), flush_cnt, m_fcnt);
`endif
      end

      // PC wrap-around
      apply(0, 1, 1, 1, 32'hFFFF_FFFC, 32'h0);
      chk("wrap.redirect", pc, 32'hFFFF_FFFC);
      apply(0, 0, 1, 1, 32'h0, 32'h66666666);
      chk("wrap.pc",       pc,          32'h0);
      chk("wrap.IF_ID_pc", IF_ID_pc,    32'hFFFF_FFFC);
      chk("wrap.instr",    IF_ID_instr, 32'h66666666);

      // Asynchronous reset while waiting on imem
      apply(0, 0, 1, 0, 32'h0, 32'h0);
      chk("wait.valid", {31'h0, IF_ID_valid}, 32'h0);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst.pc",       pc,          32'h0);
      chk("arst.IF_ID_pc", IF_ID_pc,    32'h0);
      chk("arst.instr",    IF_ID_instr, NOP);
      chk("arst.valid",    {31'h0, IF_ID_valid}, 32'h0);
      chk("arst.imem_req", {31'h0, imem_req},    32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("arst.stall_cnt", stall_cnt, 32'h0);
      chk("arst.flush_cnt", flush_cnt, 32'h0);
`endif
      @(posedge clk); #1;
      rstn = 1'b1;
      model_reset();
      apply(0, 0, 1, 1, 32'h0, 32'h0AAA0AAA);
      chk_model("reboot0");
      apply(0, 0, 1, 1, 32'h0, 32'h0BBB0BBB);
      chk_model("reboot1");

      // Randomised run against the model
      for (int k = 0; k < 3000; k++) begin
         logic s, f, w, r;
         s = ($urandom_range(99) < 15);
         w = ($urandom_range(99) >= 10);
         f = ($urandom_range(99) < 12);
         r = ($urandom_range(99) < 75);
         apply(s, f, w, r, $urandom, $urandom);
         chk_model($sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
